ifu_fetch: RTL and testbench

//   Instruction-fetch stage directly upstream of decode/EXU. Holds the PC and issues one
//   32-bit fetch at a time on a valid/ready memory port. Presents each fetched instruction

---
 rtl/ifu_fetch.sv | 165 ++++++++++++++++
 tb/tb_ifu_fetch.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module   : ifu_fetch
// Purpose  : Instruction-fetch stage with one outstanding 32-bit fetch at a time.
//            It takes branch/jump redirects and raises a sticky fetch_err.
//            Define IFU_PERF_CNT_EN to add the perf_fetch_cnt/perf_stall_cnt ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_HALT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

    state_t           r_state, w_state_nxt;
    logic [31:0]      r_pc, w_pc_nxt;
    logic             r_drop, w_drop_nxt;
    logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic             r_err, w_err_nxt;
    logic [31:0]      r_inst, r_inst_pc;
    logic             w_capture;
    logic             w_redir_bad;

    assign w_redir_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_drop_nxt     = r_drop;
        w_wait_cnt_nxt = r_wait_cnt;
        w_err_nxt      = r_err;
        w_capture      = 1'b0;

        case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                if (mem_req_ready) begin
                    w_state_nxt    = S_WAIT;
                    w_wait_cnt_nxt = '0;
                    if (redirect_valid) w_drop_nxt = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    // A redirect in the same cycle makes this response stale too.
                    w_drop_nxt = 1'b0;
                    if (!r_drop && !redirect_valid) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end else if (r_wait_cnt == c_TIMEOUT_M1) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_HALT;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                    if (redirect_valid) w_drop_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    w_pc_nxt    = r_pc + 32'd4;
                    w_state_nxt = S_REQ;
                end
                if (redirect_valid) w_state_nxt = S_REQ;
            end
            S_HALT: ;
            default: w_state_nxt = S_IDLE;
        endcase

        // Redirect target beats pc+4; a move into HALT keeps the PC frozen.
        if (redirect_valid && (r_state != S_HALT) && (w_state_nxt != S_HALT))
            w_pc_nxt = redirect_pc;

        if (w_redir_bad && (r_state != S_HALT)) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = S_HALT;
            w_pc_nxt    = r_pc;
            w_capture   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_drop     <= 1'b0;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
            r_inst     <= 32'd0;
            r_inst_pc  <= 32'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_drop     <= w_drop_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_err      <= w_err_nxt;
            if (w_capture) begin
                r_inst    <= mem_resp_data;
                r_inst_pc <= r_pc;
            end
        end
    end

    assign mem_req_valid = (r_state == S_REQ);
    assign mem_req_addr  = r_pc;
    assign inst_valid    = (r_state == S_HOLD);
    assign inst          = r_inst;
    assign inst_pc       = r_inst_pc;
    assign fetch_err     = r_err;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] r_perf_fetch, r_perf_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_fetch <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if ((r_state == S_HOLD) && inst_ready)
                r_perf_fetch <= r_perf_fetch + 32'd1;
            if ((r_state == S_REQ) || (r_state == S_WAIT))
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifu_fetch.sv
// ============================================================================
// Module   : tb_ifu_fetch
// Purpose  : Self-checking bench for ifu_fetch: a vector table, directed corner
//            sequences and random traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ifu_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h8000_0000;
    localparam int          c_TIMEOUT  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0, rv = 1'b0, ir = 1'b0, redir = 1'b0;
    logic [31:0] rd = 32'd0, rpc = 32'd0;
    logic        req_valid, iv, err;
    logic [31:0] req_addr, inst_w, ipc;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] pf_fetch, pf_stall;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    ifu_fetch #(.RESET_PC(c_RESET_PC), .TIMEOUT(c_TIMEOUT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .mem_req_valid(req_valid), .mem_req_addr(req_addr), .mem_req_ready(rdy),
        .mem_resp_valid(rv), .mem_resp_data(rd),
        .inst_valid(iv), .inst(inst_w), .inst_pc(ipc), .inst_ready(ir),
        .redirect_valid(redir), .redirect_pc(rpc),
        .fetch_err(err)
`ifdef IFU_PERF_CNT_EN
        , .perf_fetch_cnt(pf_fetch), .perf_stall_cnt(pf_stall)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, required finish before 2ms");
        $fatal(1);
    end

    // ---------------- behavioural reference model ----------------
    logic        m_err, m_started, m_out, m_drop, m_have;
    logic [31:0] m_pc, m_inst, m_ipc, m_fetch, m_stall;
    int          m_waited;

    task automatic model_reset();
        m_err = 0; m_started = 0; m_out = 0; m_drop = 0; m_have = 0;
        m_pc = c_RESET_PC; m_inst = 0; m_ipc = 0; m_fetch = 0; m_stall = 0; m_waited = 0;
    endtask

    // One clock edge seen as transactions: launch, outstanding, held word.
    task automatic model_step(input logic a_rdy, input logic a_rv, input logic [31:0] a_rd,
                              input logic a_ir, input logic a_redir, input logic [31:0] a_rpc);
        logic [31:0] pc_before;
        if (m_err) return;
        if (m_have && a_ir) m_fetch++;
        if (m_started && !m_have) m_stall++;
        if (a_redir && (a_rpc[1:0] != 2'b00)) begin
            m_err = 1; m_have = 0; m_out = 0;
            return;
        end
        pc_before = m_pc;
        if (!m_started) m_started = 1;
        else if (m_have) begin
            if (a_ir) begin m_have = 0; m_pc = m_pc + 4; end
            if (a_redir) m_have = 0;
        end else if (!m_out) begin
            if (a_rdy) begin m_out = 1; m_waited = 0; m_drop = a_redir; end
        end else if (a_rv) begin
            m_out = 0;
            if (!m_drop && !a_redir) begin m_have = 1; m_inst = a_rd; m_ipc = pc_before; end
            m_drop = 0;
        end else begin
            m_waited++;
            if (m_waited == c_TIMEOUT) begin m_err = 1; m_out = 0; return; end
            if (a_redir) m_drop = 1;
        end
        if (a_redir) m_pc = a_rpc;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_req, input logic [31:0] e_addr,
                              input logic e_iv, input logic [31:0] e_inst,
                              input logic [31:0] e_ipc, input logic e_err);
        check({tag, ".req_valid"}, {31'd0, req_valid}, {31'd0, e_req});
        check({tag, ".req_addr"},  req_addr, e_addr);
        check({tag, ".inst_valid"}, {31'd0, iv}, {31'd0, e_iv});
        check({tag, ".inst"},      inst_w, e_inst);
        check({tag, ".inst_pc"},   ipc, e_ipc);
        check({tag, ".fetch_err"}, {31'd0, err}, {31'd0, e_err});
    endtask

    task automatic drive(input logic a_rdy, input logic a_rv, input logic [31:0] a_rd,
                         input logic a_ir, input logic a_redir, input logic [31:0] a_rpc);
        rdy = a_rdy; rv = a_rv; rd = a_rd; ir = a_ir; redir = a_redir; rpc = a_rpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_outs("reset", 1'b0, c_RESET_PC, 1'b0, 32'd0, 32'd0, 1'b0);
`ifdef IFU_PERF_CNT_EN
        check("reset.perf_fetch", pf_fetch, 32'd0);
        check("reset.perf_stall", pf_stall, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        rdy, rv;
        logic [31:0] rd;
        logic        ir, redir;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst, e_ipc;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input logic a_rdy, input logic a_rv, input logic [31:0] a_rd,
                                input logic a_ir, input logic a_redir, input logic [31:0] a_rpc,
                                input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                                input logic [31:0] e_inst, input logic [31:0] e_ipc,
                                input logic e_err);
        vec_t v;
        v.rdy = a_rdy; v.rv = a_rv; v.rd = a_rd; v.ir = a_ir; v.redir = a_redir; v.rpc = a_rpc;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
        v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_err = e_err;
        return v;
    endfunction

    vec_t vt[14];

    initial begin
        logic [31:0] t, a;
        // rdy rv  data          ir redir target          req addr           iv inst          inst_pc       err
        vt[0]  = mk(1, 0, 32'h0,        1, 0, 32'h0,         1, 32'h8000_0000, 0, 32'h0,        32'h0,         0);
        vt[1]  = mk(1, 0, 32'h0,        1, 0, 32'h0,         0, 32'h8000_0000, 0, 32'h0,        32'h0,         0);
        vt[2]  = mk(0, 1, 32'h1111_0000, 0, 0, 32'h0,        0, 32'h8000_0000, 1, 32'h1111_0000, 32'h8000_0000, 0);
        vt[3]  = mk(0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h8000_0004, 0, 32'h1111_0000, 32'h8000_0000, 0);
        vt[4]  = mk(1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h8000_0004, 0, 32'h1111_0000, 32'h8000_0000, 0);
        vt[5]  = mk(0, 1, 32'h2222_0000, 0, 0, 32'h0,        0, 32'h8000_0004, 1, 32'h2222_0000, 32'h8000_0004, 0);
        vt[6]  = mk(0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h8000_0008, 0, 32'h2222_0000, 32'h8000_0004, 0);
        vt[7]  = mk(1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h8000_0008, 0, 32'h2222_0000, 32'h8000_0004, 0);
        vt[8]  = mk(0, 0, 32'h0,        0, 1, 32'h8000_0100, 0, 32'h8000_0100, 0, 32'h2222_0000, 32'h8000_0004, 0);
        vt[9]  = mk(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,        1, 32'h8000_0100, 0, 32'h2222_0000, 32'h8000_0004, 0);
        vt[10] = mk(1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h8000_0100, 0, 32'h2222_0000, 32'h8000_0004, 0);
        vt[11] = mk(0, 1, 32'h3333_0000, 0, 0, 32'h0,        0, 32'h8000_0100, 1, 32'h3333_0000, 32'h8000_0100, 0);
        vt[12] = mk(0, 0, 32'h0,        0, 1, 32'h8000_0102, 0, 32'h8000_0100, 0, 32'h3333_0000, 32'h8000_0100, 1);
        vt[13] = mk(1, 0, 32'h0,        1, 0, 32'h0,         0, 32'h8000_0100, 0, 32'h3333_0000, 32'h8000_0100, 1);

        // Table: back-to-back fetches, drop after redirect, misaligned redirect.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            drive(vt[i].rdy, vt[i].rv, vt[i].rd, vt[i].ir, vt[i].redir, vt[i].rpc);
            tick();
            check_outs($sformatf("vec%0d", i), vt[i].e_req, vt[i].e_addr, vt[i].e_iv,
                       vt[i].e_inst, vt[i].e_ipc, vt[i].e_err);
        end

        // Decode stall in HOLD, then REQ/HOLD/REQ+ready redirects.
        do_reset();
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 32'h4444_0000, 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 32'hBAD0_0000, 0, 0, 0); tick();
            check_outs($sformatf("stall%0d", i), 0, 32'h8000_0000, 1, 32'h4444_0000, 32'h8000_0000, 0);
        end
        drive(0, 0, 0, 1, 0, 0); tick();
        check_outs("stall.release", 1, 32'h8000_0004, 0, 32'h4444_0000, 32'h8000_0000, 0);
        drive(0, 0, 0, 0, 1, 32'h8000_0200); tick();
        check_outs("req.redir", 1, 32'h8000_0200, 0, 32'h4444_0000, 32'h8000_0000, 0);
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 32'h5555_0000, 0, 0, 0); tick();
        check_outs("req.redir.fetch", 0, 32'h8000_0200, 1, 32'h5555_0000, 32'h8000_0200, 0);
        drive(0, 0, 0, 1, 1, 32'h8000_0300); tick();
        check_outs("hold.redir", 1, 32'h8000_0300, 0, 32'h5555_0000, 32'h8000_0200, 0);
        drive(1, 0, 0, 0, 1, 32'h8000_0400); tick();
        check_outs("reqrdy.redir", 0, 32'h8000_0400, 0, 32'h5555_0000, 32'h8000_0200, 0);
        drive(0, 1, 32'h6666_0000, 0, 0, 0); tick();
        check_outs("reqrdy.drop", 1, 32'h8000_0400, 0, 32'h5555_0000, 32'h8000_0200, 0);
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 32'h7777_0000, 0, 0, 0); tick();
        check_outs("reqrdy.refetch", 0, 32'h8000_0400, 1, 32'h7777_0000, 32'h8000_0400, 0);

        // Memory timeout, then late response and async reset recovery.
        do_reset();
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < c_TIMEOUT; i++) begin
            drive(0, 0, 0, 0, 0, 0); tick();
            check({"timeout.err", $sformatf("%0d", i)}, {31'd0, err},
                  (i == c_TIMEOUT - 1) ? 32'd1 : 32'd0);
        end
        drive(1, 1, 32'h9999_0000, 1, 0, 0); tick(); tick();
        check_outs("halt", 0, 32'h8000_0000, 0, 32'h0, 32'h0, 1);
`ifdef IFU_PERF_CNT_EN
        check("halt.perf_stall", pf_stall, 32'd5);
`endif
        do_reset();
        drive(0, 1, 32'h9999_0000, 0, 0, 0); tick();
        check_outs("late.resp", 1, 32'h8000_0000, 0, 32'h0, 32'h0, 0);

        // PC wraps past the top of the address space.
        do_reset();
        drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC); tick();
        check_outs("idle.redir", 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0, 0);
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(0, 1, 32'hAAAA_0000, 0, 0, 0); tick();
        drive(0, 0, 0, 1, 0, 0); tick();
        check_outs("wrap", 1, 32'h0000_0000, 0, 32'hAAAA_0000, 32'hFFFF_FFFC, 0);

`ifdef IFU_PERF_CNT_EN
        do_reset();
        drive(1, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0, 0); tick();
            drive(0, 1, 32'h1000 + i, 0, 0, 0); tick();
            drive(0, 0, 0, 1, 0, 0); tick();
        end
        check("perf.fetch", pf_fetch, 32'd3);
        check("perf.stall", pf_stall, 32'd6);
`endif

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ((($urandom % 200) == 0) || (m_err && (($urandom % 6) == 0))) do_reset();
            t = $urandom;
            a = $urandom;
            rdy   = t[0];
            ir    = t[1];
            rv    = (t[4:2] < 3'd3);
            redir = (t[8:5] == 4'd0);
            rpc   = {a[31:2], (t[12:9] == 4'd0) ? t[14:13] : 2'b00};
            rd    = $urandom;
            model_step(rdy, rv, rd, ir, redir, rpc);
            tick();
            check_outs($sformatf("rnd%0d", i), !m_err && m_started && !m_out && !m_have,
                       m_pc, !m_err && m_have, m_inst, m_ipc, m_err);
`ifdef IFU_PERF_CNT_EN
            check($sformatf("rnd%0d.perf_fetch", i), pf_fetch, m_fetch);
            check($sformatf("rnd%0d.perf_stall", i), pf_stall, m_stall);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
